// File: rtl/fxp_div_iter.sv
// Signed QN.Q fixed-point divider, out = a / b, one quotient bit per clock.
// Ports: clk, rst_n, in_valid/in_ready + a/b in, out_valid/out_ready + out/div_zero/ovf out.
module fxp_div_iter #(
  parameter int N = 32,
  parameter int Q = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         div_zero,
  output logic         ovf
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(N + Q + 1);

  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0] LIM  =
    {{(W-1){1'b0}}, 1'b1} << (N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t         state_q;
  logic [W-1:0]   div_q;
  logic [N:0]     rem_q;
  logic [N-1:0]   bmag_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q;
  logic           dz_q;
  logic           az_q;

  logic [N-1:0]   amag_d;
  logic [N-1:0]   bmag_d;
  logic [N:0]     rem_sh;
  logic [N:0]     rem_d;
  logic           ge;
  logic [W-1:0]   div_d;
  logic [N-1:0]   res_d;
  logic           dzo_d;
  logic           ovf_d;

  always_comb begin
    amag_d = a[N-1] ? -a : a;
    bmag_d = b[N-1] ? -b : b;
    // div_q holds the unconsumed dividend on top and the quotient
    // bits filling in from the bottom.
    rem_sh = (rem_q << 1) | {{N{1'b0}}, div_q[W-1]};
    ge     = rem_sh >= {1'b0, bmag_q};
    rem_d  = ge ? rem_sh - {1'b0, bmag_q} : rem_sh;
    div_d  = {div_q[W-2:0], ge};
  end

  always_comb begin
    res_d = '0;
    dzo_d = 1'b0;
    ovf_d = 1'b0;
    if (dz_q) begin
      dzo_d = 1'b1;
      if (az_q)       res_d = '0;
      else if (neg_q) res_d = MINV;
      else            res_d = MAXV;
    end else if (!neg_q && div_q >= LIM) begin
      res_d = MAXV;
      ovf_d = 1'b1;
    end else if (neg_q && div_q > LIM) begin
      res_d = MINV;
      ovf_d = 1'b1;
    end else begin
      res_d = neg_q ? -div_q[N-1:0] : div_q[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      bmag_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      az_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            div_q    <= W'(amag_d) << Q;
            rem_q    <= '0;
            bmag_q   <= bmag_d;
            neg_q    <= a[N-1] ^ b[N-1];
            dz_q     <= (b == '0);
            az_q     <= (a == '0);
            cnt_q    <= CW'(W);
            in_ready <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          div_q <= div_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          out       <= res_d;
          div_zero  <= dzo_d;
          ovf       <= ovf_d;
          out_valid <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div_iter.sv
// Bench for fxp_div_iter: directed vectors, reset abort, random ops vs model.
// Model divides magnitudes with plain integer arithmetic, then saturates.
module tb_fxp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        div_zero;
  logic        ovf;

  int nchk = 0;
  int nfail = 0;

  logic [31:0] exp_out;
  logic        exp_dz;
  logic        exp_ov;
  logic        exp_act = 1'b0;

  always #5 clk = ~clk;

  fxp_div_iter #(.N(32), .Q(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ma,
                                input logic [31:0] mb,
                                output logic [31:0] o,
                                output logic dz,
                                output logic ov);
    longint unsigned am, bm, qm;
    bit neg;
    o = 32'h0; dz = 1'b0; ov = 1'b0;
    if (mb == 32'h0) begin
      dz = 1'b1;
      if (ma == 32'h0) o = 32'h0;
      else if (ma[31]) o = 32'h8000_0000;
      else o = 32'h7FFF_FFFF;
    end else begin
      am = ma[31] ? 64'h1_0000_0000 - 64'(ma) : 64'(ma);
      bm = mb[31] ? 64'h1_0000_0000 - 64'(mb) : 64'(mb);
      qm = (am << 12) / bm;
      neg = ma[31] ^ mb[31];
      if (!neg && qm > 64'h7FFF_FFFF) begin
        o = 32'h7FFF_FFFF; ov = 1'b1;
      end else if (neg && qm > 64'h8000_0000) begin
        o = 32'h8000_0000; ov = 1'b1;
      end else if (neg) begin
        o = 32'(64'h1_0000_0000 - qm);
      end else begin
        o = qm[31:0];
      end
    end
  endfunction

  // Outputs are checked against the model on every cycle they are valid.
  always @(negedge clk) begin
    if (rst_n && out_valid && exp_act) begin
      chk("out", dout, exp_out);
      chk("div_zero", 32'(div_zero), 32'(exp_dz));
      chk("ovf", 32'(ovf), 32'(exp_ov));
      chk("in_ready_done", 32'(in_ready), 32'd0);
    end
  end

  task automatic run_op(input logic [31:0] ta,
                        input logic [31:0] tbv,
                        input int hold,
                        output logic [31:0] ro,
                        output logic rdz,
                        output logic rov);
    int n;
    @(negedge clk);
    a = ta; b = tbv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    chk("accept_wait", 32'(n), 32'd0);
    @(posedge clk);
    model(ta, tbv, exp_out, exp_dz, exp_ov);
    exp_act = 1'b1;
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'd45);
    ro = dout; rdz = div_zero; rov = ovf;
    repeat (hold) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("out_retained", dout, ro);
  endtask

  logic [31:0] va [11] = '{32'h0000_6000, 32'h0000_1000, 32'hFFFF_F000,
                           32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_1000,
                           32'hFFFF_F000, 32'h0000_0000, 32'h8000_0000,
                           32'hC000_0000, 32'h8000_0000};
  logic [31:0] vb [11] = '{32'h0000_2000, 32'h0000_3000, 32'h0000_3000,
                           32'h0000_1000, 32'h0000_0001, 32'h0000_0000,
                           32'h0000_0000, 32'h0000_0000, 32'hFFFF_F000,
                           32'h0000_0800, 32'h0000_0800};
  logic [31:0] vo [11] = '{32'h0000_3000, 32'h0000_0555, 32'hFFFF_FAAB,
                           32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                           32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF,
                           32'h8000_0000, 32'h8000_0000};
  logic vdz [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
  logic vov [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};

  initial begin
    logic [31:0] ro, ra, rb;
    logic rdz, rov;
    int n, r;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", dout, 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(va[i], vb[i], (i == 0) ? 10 : 1, ro, rdz, rov);
      chk($sformatf("lit_out%0d", i), ro, vo[i]);
      chk($sformatf("lit_dz%0d", i), 32'(rdz), 32'(vdz[i]));
      chk($sformatf("lit_ovf%0d", i), 32'(rov), 32'(vov[i]));
    end

    // Abort an operation partway through the iterations.
    @(negedge clk);
    a = 32'h0000_6000; b = 32'h0000_2000; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_act = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_1000, 32'h0000_3000, 0, ro, rdz, rov);
    chk("after_abort", ro, 32'h0000_0555);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: rb = 32'h0;
        1, 2: rb = 32'($urandom_range(1, 16));
        3: rb = 32'h0000_1000;
        default: rb = $urandom;
      endcase
      r = $urandom_range(0, 9);
      case (r)
        0: ra = 32'h0;
        1: ra = 32'h8000_0000;
        2: ra = 32'($urandom_range(0, 65535));
        default: ra = $urandom;
      endcase
      run_op(ra, rb, $urandom_range(0, 2), ro, rdz, rov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
